// File: rtl/qconv_threshold_output.sv
// Output stage of the qconv tile: reads accumulators, quantizes them to 2 bits against
// per-channel thresholds and writes packed words downstream. QCONV_TH_INVERT_EN adds th_rd_flag.
module qconv_threshold_output #(
   parameter int unsigned  OcNum        = 16,
   parameter int unsigned  PixNum       = 4,
   parameter int unsigned  AccWidth     = 16,
   parameter int unsigned  AddrWidth    = 8,
   parameter int unsigned  OutAddrWidth = 16,
   localparam int unsigned OutWidth     = 2 * OcNum
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    finish,
   input  logic [OutAddrWidth-1:0] out_base,
   output logic [AddrWidth-1:0]    acc_rd_addr,
   output logic                    acc_rd_en,
   input  logic [AccWidth-1:0]     acc_rd_data,
   output logic [3:0]              th_rd_addr,
   input  logic [3*AccWidth-1:0]   th_rd_data,
`ifdef QCONV_TH_INVERT_EN
   input  logic                    th_rd_flag,
`endif
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OutAddrWidth-1:0] out_addr,
   output logic [OutWidth-1:0]     out_data
);

   localparam int unsigned OcW  = (OcNum > 1) ? $clog2(OcNum) : 1;
   localparam int unsigned PixW = (PixNum > 1) ? $clog2(PixNum) : 1;

   typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, FINISH} state_e;

   state_e                  state_q, state_d;
   logic [PixW-1:0]         pix_q, pix_d;
   logic [OcW-1:0]          oc_q, oc_d;
   logic [OutAddrWidth-1:0] base_q, base_d;
   logic                    rd_en_q, rd_en_d;
   logic [AddrWidth-1:0]    rd_addr_q, rd_addr_d;
   logic [3:0]              th_addr_q, th_addr_d;
   logic                    out_valid_q, out_valid_d;
   logic [OutAddrWidth-1:0] out_addr_q, out_addr_d;
   logic                    finish_q, finish_d;
   logic [OutWidth-1:0]     pack_q, pack_d;
   logic                    vld_q;
   logic [OcW-1:0]          idx_q;

   // Signed threshold compares on the returning read data
   logic signed [AccWidth-1:0] acc_s, th0_s, th1_s, th2_s;
   logic                       hit0_c, hit1_c, hit2_c;
   logic [1:0]                 q_c;

   assign acc_s = acc_rd_data;
   assign th0_s = th_rd_data[AccWidth-1:0];
   assign th1_s = th_rd_data[2*AccWidth-1:AccWidth];
   assign th2_s = th_rd_data[3*AccWidth-1:2*AccWidth];

`ifdef QCONV_TH_INVERT_EN
   assign hit0_c = th_rd_flag ? (acc_s <= th0_s) : (acc_s >= th0_s);
   assign hit1_c = th_rd_flag ? (acc_s <= th1_s) : (acc_s >= th1_s);
   assign hit2_c = th_rd_flag ? (acc_s <= th2_s) : (acc_s >= th2_s);
`else
   assign hit0_c = (acc_s >= th0_s);
   assign hit1_c = (acc_s >= th1_s);
   assign hit2_c = (acc_s >= th2_s);
`endif

   assign q_c = 2'(hit0_c) + 2'(hit1_c) + 2'(hit2_c);

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      pix_d       = pix_q;
      oc_d        = oc_q;
      base_d      = base_q;
      rd_en_d     = 1'b0;
      rd_addr_d   = rd_addr_q;
      th_addr_d   = th_addr_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      finish_d    = 1'b0;
      pack_d      = pack_q;

      if (vld_q) begin
         pack_d[2*idx_q +: 2] = q_c;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               base_d  = out_base;
               pix_d   = '0;
               oc_d    = '0;
               rd_en_d = 1'b1;
               state_d = READ;
            end
         end
         READ: begin
            if (oc_q == OcW'(OcNum - 1)) begin
               state_d = DRAIN;
            end else begin
               oc_d    = oc_q + OcW'(1);
               rd_en_d = 1'b1;
            end
         end
         DRAIN: begin
            out_valid_d = 1'b1;
            out_addr_d  = base_q + OutAddrWidth'(pix_q);
            state_d     = WRITE;
         end
         WRITE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (pix_q != PixW'(PixNum - 1)) begin
                  pix_d   = pix_q + PixW'(1);
                  oc_d    = '0;
                  rd_en_d = 1'b1;
                  state_d = READ;
               end else begin
                  finish_d = 1'b1;
                  state_d  = FINISH;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (rd_en_d) begin
         rd_addr_d = AddrWidth'(32'(pix_d) * OcNum + 32'(oc_d));
         th_addr_d = 4'(oc_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pix_q       <= '0;
         oc_q        <= '0;
         base_q      <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         th_addr_q   <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         finish_q    <= 1'b0;
         pack_q      <= '0;
         vld_q       <= 1'b0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         pix_q       <= pix_d;
         oc_q        <= oc_d;
         base_q      <= base_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         th_addr_q   <= th_addr_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         finish_q    <= finish_d;
         pack_q      <= pack_d;
         vld_q       <= rd_en_q;
         idx_q       <= oc_q;
      end
   end

   assign finish      = finish_q;
   assign acc_rd_en   = rd_en_q;
   assign acc_rd_addr = rd_addr_q;
   assign th_rd_addr  = th_addr_q;
   assign out_valid   = out_valid_q;
   assign out_addr    = out_addr_q;
   assign out_data    = pack_q;

endmodule

// File: tb/tb_qconv_threshold_output.sv
// Directed testbench for qconv_threshold_output; models the output and threshold buffers.
module tb_qconv_threshold_output;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        finish;
   logic [15:0] out_base;
   logic [7:0]  acc_rd_addr;
   logic        acc_rd_en;
   logic [15:0] acc_rd_data;
   logic [3:0]  th_rd_addr;
   logic [47:0] th_rd_data;
   logic        th_rd_flag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_addr;
   logic [31:0] out_data;

   always #5 clk = ~clk;

   qconv_threshold_output dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .finish      (finish),
      .out_base    (out_base),
      .acc_rd_addr (acc_rd_addr),
      .acc_rd_en   (acc_rd_en),
      .acc_rd_data (acc_rd_data),
      .th_rd_addr  (th_rd_addr),
      .th_rd_data  (th_rd_data),
`ifdef QCONV_TH_INVERT_EN
      .th_rd_flag  (th_rd_flag),
`endif
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_addr    (out_addr),
      .out_data    (out_data)
   );

   logic [15:0] acc_mem [0:255];
   logic [47:0] th_mem  [0:15];
   logic        flag_mem[0:15];

   // Registered read: data appears the cycle after acc_rd_en
   always @(posedge clk) begin
      if (acc_rd_en) begin
         acc_rd_data <= acc_mem[acc_rd_addr];
         th_rd_data  <= th_mem[th_rd_addr];
         th_rd_flag  <= flag_mem[th_rd_addr];
      end
   end

   int          vectors = 0;
   int          errors  = 0;
   logic [31:0] wq_data[$];
   logic [15:0] wq_addr[$];
   int          fin_edge;
   int          fin_cnt;
   bit          unstable;

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) acc_mem[i] = 16'h0000;
      for (int c = 0; c < 16; c++) begin
         th_mem[c]   = {16'd1, 16'd1, 16'd1};
         flag_mem[c] = 1'b0;
      end
   endtask

   task automatic load_basic();
      clear_mem();
      for (int p = 0; p < 4; p++)
         for (int c = 0; c < 16; c++) acc_mem[p*16+c] = 16'(100*c - 50);
      for (int c = 0; c < 16; c++) th_mem[c] = {16'd300, 16'd200, 16'd100};
   endtask

   task automatic load_signed();
      clear_mem();
      th_mem[0] = {16'h0000, 16'hFFFF, 16'h8000};
      th_mem[1] = {16'h7FFF, 16'h7FFF, 16'h7FFF};
      th_mem[2] = {16'h0000, 16'hFFFF, 16'h8000};
      for (int p = 0; p < 4; p++) begin
         acc_mem[p*16+0]     = 16'h8000;
         acc_mem[p*16+1]     = 16'h7FFF;
         acc_mem[p*16+2]     = 16'hFFFF;
         acc_mem[p*16+3+p]   = 16'h0001;
      end
   endtask

   // Runs one tile from IDLE; e is the index of the clock edge just passed (edge 0 samples start)
   task automatic run_tile(input logic [15:0] base, input int stall, input int sp0, input int sp1);
      int          held;
      logic [31:0] hd;
      logic [15:0] ha;
      wq_data.delete();
      wq_addr.delete();
      fin_edge = -1;
      fin_cnt  = 0;
      unstable = 1'b0;
      held     = 0;
      hd       = '0;
      ha       = '0;
      @(negedge clk);
      out_base  = base;
      start     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      for (int e = 0; e < 400; e++) begin
         @(negedge clk);
         start = ((e + 1) == sp0) || ((e + 1) == sp1);
         if (finish) begin
            fin_cnt++;
            if (fin_edge < 0) fin_edge = e;
         end
         if (out_valid) begin
            if (held == 0) begin
               hd = out_data;
               ha = out_addr;
            end else if (out_data !== hd || out_addr !== ha) begin
               unstable = 1'b1;
            end
            if (held < stall) begin
               out_ready = 1'b0;
               held++;
            end else begin
               out_ready = 1'b1;
               wq_data.push_back(out_data);
               wq_addr.push_back(out_addr);
               held = 0;
            end
         end else begin
            out_ready = 1'b1;
            held      = 0;
         end
         if (fin_edge >= 0 && e >= fin_edge + 3) break;
      end
      start     = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      vectors++;
      if ({finish, out_valid, acc_rd_en} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 000", {finish, out_valid, acc_rd_en});
      end
      vectors++;
      if (out_data !== 32'h0 || out_addr !== 16'h0) begin
         errors++;
         $display("FAIL reset_data: got data %h addr %h expected 0 0", out_data, out_addr);
      end
      vectors++;
      if (acc_rd_addr !== 8'h0 || th_rd_addr !== 4'h0) begin
         errors++;
         $display("FAIL reset_rdaddr: got %h/%h expected 0/0", acc_rd_addr, th_rd_addr);
      end
   endtask

   task automatic test_basic();
      load_basic();
      run_tile(16'h0040, 0, -1, -1);
      vectors++;
      if (wq_data.size() != 4) begin
         errors++;
         $display("FAIL basic_count: got %0d expected 4", wq_data.size());
      end
      for (int i = 0; i < wq_data.size(); i++) begin
         vectors++;
         if (wq_data[i] !== 32'hFFFF_FF90 || wq_addr[i] !== 16'(16'h0040 + i)) begin
            errors++;
            $display("FAIL basic_word[%0d]: got %h@%h expected ffffff90@%h",
                     i, wq_data[i], wq_addr[i], 16'(16'h0040 + i));
         end
      end
      vectors++;
      if (fin_edge != 72 || fin_cnt != 1) begin
         errors++;
         $display("FAIL basic_finish: got edge %0d pulses %0d expected 72 1", fin_edge, fin_cnt);
      end
   endtask

   task automatic test_signed_edges();
      logic [31:0] exp_w[4];
      exp_w[0] = 32'h0000_00ED;
      exp_w[1] = 32'h0000_032D;
      exp_w[2] = 32'h0000_0C2D;
      exp_w[3] = 32'h0000_302D;
      load_signed();
      run_tile(16'h0000, 0, -1, -1);
      vectors++;
      if (wq_data.size() != 4) begin
         errors++;
         $display("FAIL signed_count: got %0d expected 4", wq_data.size());
      end
      for (int i = 0; i < wq_data.size() && i < 4; i++) begin
         vectors++;
         if (wq_data[i] !== exp_w[i]) begin
            errors++;
            $display("FAIL signed_word[%0d]: got %h expected %h", i, wq_data[i], exp_w[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_w[4];
      exp_w[0] = 32'h0000_00ED;
      exp_w[1] = 32'h0000_032D;
      exp_w[2] = 32'h0000_0C2D;
      exp_w[3] = 32'h0000_302D;
      load_signed();
      run_tile(16'h0100, 5, -1, -1);
      vectors++;
      if (wq_data.size() != 4 || unstable) begin
         errors++;
         $display("FAIL bp_count_stable: got %0d words unstable=%0d expected 4 0",
                  wq_data.size(), unstable);
      end
      for (int i = 0; i < wq_data.size() && i < 4; i++) begin
         vectors++;
         if (wq_data[i] !== exp_w[i] || wq_addr[i] !== 16'(16'h0100 + i)) begin
            errors++;
            $display("FAIL bp_word[%0d]: got %h@%h expected %h@%h",
                     i, wq_data[i], wq_addr[i], exp_w[i], 16'(16'h0100 + i));
         end
      end
      vectors++;
      if (fin_edge != 92 || fin_cnt != 1) begin
         errors++;
         $display("FAIL bp_finish: got edge %0d pulses %0d expected 92 1", fin_edge, fin_cnt);
      end
   endtask

   task automatic test_start_ignored();
      load_basic();
      run_tile(16'h0200, 0, 5, 40);
      vectors++;
      if (wq_data.size() != 4 || fin_edge != 72 || fin_cnt != 1) begin
         errors++;
         $display("FAIL start_ignored: got %0d words edge %0d pulses %0d expected 4 72 1",
                  wq_data.size(), fin_edge, fin_cnt);
      end
   endtask

   task automatic test_addr_wrap();
      logic [15:0] exp_a[4];
      exp_a[0] = 16'hFFFE;
      exp_a[1] = 16'hFFFF;
      exp_a[2] = 16'h0000;
      exp_a[3] = 16'h0001;
      load_basic();
      run_tile(16'hFFFE, 0, -1, -1);
      vectors++;
      if (wq_addr.size() != 4) begin
         errors++;
         $display("FAIL wrap_count: got %0d expected 4", wq_addr.size());
      end
      for (int i = 0; i < wq_addr.size() && i < 4; i++) begin
         vectors++;
         if (wq_addr[i] !== exp_a[i]) begin
            errors++;
            $display("FAIL wrap_addr[%0d]: got %h expected %h", i, wq_addr[i], exp_a[i]);
         end
      end
   endtask

   task automatic test_reset_mid_write();
      load_basic();
      @(negedge clk);
      out_base  = 16'h0020;
      out_ready = 1'b0;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int e = 1; e < 18; e++) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_addr !== 16'h0020) begin
         errors++;
         $display("FAIL rst_pre_write: got valid %b addr %h expected 1 0020", out_valid, out_addr);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || finish !== 1'b0 || out_addr !== 16'h0 || acc_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: got valid %b finish %b addr %h rd_en %b expected 0 0 0000 0",
                  out_valid, finish, out_addr, acc_rd_en);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      run_tile(16'h0030, 0, -1, -1);
      vectors++;
      if (wq_addr.size() != 4 || fin_edge != 72) begin
         errors++;
         $display("FAIL rst_rerun: got %0d words edge %0d expected 4 72", wq_addr.size(), fin_edge);
      end else if (wq_addr[0] !== 16'h0030 || wq_addr[3] !== 16'h0033) begin
         errors++;
         $display("FAIL rst_rerun_addr: got %h..%h expected 0030..0033", wq_addr[0], wq_addr[3]);
      end
   endtask

`ifdef QCONV_TH_INVERT_EN
   task automatic test_invert();
      clear_mem();
      th_mem[0]   = {16'd300, 16'd200, 16'd100};
      th_mem[1]   = {16'd300, 16'd200, 16'd100};
      flag_mem[0] = 1'b1;
      for (int p = 0; p < 4; p++) begin
         acc_mem[p*16+0] = 16'd150;
         acc_mem[p*16+1] = 16'd150;
      end
      run_tile(16'h0000, 0, -1, -1);
      vectors++;
      if (wq_data.size() != 4) begin
         errors++;
         $display("FAIL inv_count: got %0d expected 4", wq_data.size());
      end else if (wq_data[0] !== 32'h0000_0006) begin
         errors++;
         $display("FAIL inv_word: got %h expected 00000006", wq_data[0]);
      end
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      out_base  = 16'h0;
      clear_mem();
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_basic();
      test_signed_edges();
      test_backpressure();
      test_start_ignored();
      test_addr_wrap();
      test_reset_mid_write();
`ifdef QCONV_TH_INVERT_EN
      test_invert();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
